// File: rtl/morse_beep_seq_if.sv
// Bus interface for morse_beep_seq: character request fields in, buzzer and status out.
// The master drives the request fields; the slave (the sequencer) drives the status.
interface morse_beep_seq_if #(
    parameter int unsigned MAX_SYM = 5,
    parameter int unsigned UNIT_W  = 16,
    parameter int unsigned LEN_W   = 4
);
    localparam int unsigned CntW = $clog2(MAX_SYM + 1);

    logic               start;
    logic [MAX_SYM-1:0] code;
    logic [CntW-1:0]    code_len;
    logic [UNIT_W-1:0]  unit_div;
    logic [LEN_W-1:0]   dot_len;
    logic [LEN_W-1:0]   dash_len;
    logic [LEN_W-1:0]   gap_len;
    logic               beep;
    logic               busy;
    logic               done;
    logic [CntW-1:0]    sym_idx;

    modport master (
        output start, code, code_len, unit_div, dot_len, dash_len, gap_len,
        input  beep, busy, done, sym_idx
    );

    modport slave (
        input  start, code, code_len, unit_div, dot_len, dash_len, gap_len,
        output beep, busy, done, sym_idx
    );
endinterface

// File: rtl/morse_beep_seq.sv
// Morse character sequencer: plays up to MAX_SYM dots/dashes, each followed by a gap.
// Define BEEP_TONE_EN to drive beep as a TONE_DIV square wave during tones instead of DC.
module morse_beep_seq #(
    parameter int unsigned MAX_SYM  = 5,
    parameter int unsigned UNIT_W   = 16,
    parameter int unsigned LEN_W    = 4,
    parameter int unsigned TONE_DIV = 2500
) (
    input logic             clk,
    input logic             rst,
    morse_beep_seq_if.slave bus
);
    localparam int unsigned CntW = $clog2(MAX_SYM + 1);

    typedef enum logic [1:0] {
        StIdle,
        StTone,
        StGap
    } state_e;

    state_e             state_q;
    logic [MAX_SYM-1:0] code_q;
    logic [CntW-1:0]    len_q;
    logic [UNIT_W-1:0]  udiv_q;
    logic [LEN_W-1:0]   dot_q;
    logic [LEN_W-1:0]   dash_q;
    logic [LEN_W-1:0]   gap_q;
    logic [UNIT_W-1:0]  presc_q;
    logic [LEN_W-1:0]   units_q;
    logic [CntW-1:0]    sym_idx_q;
    logic               beep_q;
    logic               busy_q;
    logic               done_q;

`ifdef BEEP_TONE_EN
    localparam int unsigned TdW = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
    logic [TdW-1:0] tdiv_q;
`endif

    logic [UNIT_W-1:0] presc_d;
    logic [LEN_W-1:0]  units_d;
    logic [LEN_W-1:0]  cur_len;
    logic [CntW-1:0]   sym_idx_d;
    logic [CntW-1:0]   start_len;
    logic              unit_tick;
    logic              elem_end;

    // Zero-length fields are treated as one unit.
    function automatic logic [LEN_W-1:0] nz_len(input logic [LEN_W-1:0] l);
        return (l == '0) ? LEN_W'(1) : l;
    endfunction

    always_comb begin
        unit_tick = (presc_q == udiv_q);
        presc_d   = unit_tick ? '0 : presc_q + UNIT_W'(1);
        units_d   = unit_tick ? units_q + LEN_W'(1) : units_q;
        cur_len   = gap_q;
        if (state_q == StTone) begin
            cur_len = code_q[sym_idx_q] ? dash_q : dot_q;
        end
        elem_end  = unit_tick && (units_q == cur_len - LEN_W'(1));
        sym_idx_d = sym_idx_q + CntW'(1);
        start_len = (bus.code_len > CntW'(MAX_SYM)) ? CntW'(MAX_SYM) : bus.code_len;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            code_q    <= '0;
            len_q     <= '0;
            udiv_q    <= '0;
            dot_q     <= '0;
            dash_q    <= '0;
            gap_q     <= '0;
            presc_q   <= '0;
            units_q   <= '0;
            sym_idx_q <= '0;
            beep_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef BEEP_TONE_EN
            tdiv_q    <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        code_q    <= bus.code;
                        len_q     <= start_len;
                        udiv_q    <= bus.unit_div;
                        dot_q     <= nz_len(bus.dot_len);
                        dash_q    <= nz_len(bus.dash_len);
                        gap_q     <= nz_len(bus.gap_len);
                        presc_q   <= '0;
                        units_q   <= '0;
                        sym_idx_q <= '0;
`ifdef BEEP_TONE_EN
                        tdiv_q    <= '0;
`endif
                        if (start_len == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q <= StTone;
                            beep_q  <= 1'b1;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                StTone: begin
                    if (elem_end) begin
                        state_q <= StGap;
                        presc_q <= '0;
                        units_q <= '0;
                        beep_q  <= 1'b0;
                    end else begin
                        presc_q <= presc_d;
                        units_q <= units_d;
`ifdef BEEP_TONE_EN
                        if (tdiv_q == TdW'(TONE_DIV - 1)) begin
                            tdiv_q <= '0;
                            beep_q <= ~beep_q;
                        end else begin
                            tdiv_q <= tdiv_q + TdW'(1);
                        end
`endif
                    end
                end
                StGap: begin
                    if (elem_end) begin
                        presc_q <= '0;
                        units_q <= '0;
                        if (sym_idx_d < len_q) begin
                            state_q   <= StTone;
                            sym_idx_q <= sym_idx_d;
                            beep_q    <= 1'b1;
`ifdef BEEP_TONE_EN
                            tdiv_q    <= '0;
`endif
                        end else begin
                            state_q   <= StIdle;
                            sym_idx_q <= '0;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                        end
                    end else begin
                        presc_q <= presc_d;
                        units_q <= units_d;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.beep    = beep_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.sym_idx = sym_idx_q;
endmodule

// File: tb/tb_morse_beep_seq.sv
// Directed bench for morse_beep_seq: per-cycle beep/busy/done against hand-derived vectors.
// Bit c of each expectation vector is the value in cycle c, with start sampled in cycle 0.
module tb_morse_beep_seq;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    morse_beep_seq_if #(.MAX_SYM(5), .UNIT_W(16), .LEN_W(4)) bus ();

    morse_beep_seq #(
        .MAX_SYM (5),
        .UNIT_W  (16),
        .LEN_W   (4),
        .TONE_DIV(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef BEEP_TONE_EN
    localparam logic [31:0] BeepA = 32'h9A;   // dash plays 1,1,0 with TONE_DIV=2
    localparam logic [31:0] BeepB = 32'h66;
`else
    localparam logic [31:0] BeepA = 32'hBA;
    localparam logic [31:0] BeepB = 32'h1FE;
`endif
    localparam logic [63:0] SymA = 64'h0000_0002_2111_1000;

    task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic setup(input logic [15:0] udiv, input logic [3:0] dot, input logic [3:0] dash,
                         input logic [3:0] gap, input logic [4:0] code, input logic [2:0] len);
        bus.unit_div = udiv;
        bus.dot_len  = dot;
        bus.dash_len = dash;
        bus.gap_len  = gap;
        bus.code     = code;
        bus.code_len = len;
    endtask

    // inj: 0 none, 1 start pulse after checking cycle inj_c, 2 reset pulse after cycle inj_c.
    task automatic run(input string tag, input int n, input logic [31:0] eb,
                       input logic [31:0] ebusy, input logic [31:0] edone, input bit chk_sym,
                       input logic [63:0] esym, input int inj, input int inj_c, input bit scramble);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        if (scramble) setup(16'h7, 4'h9, 4'h9, 4'h9, 5'b10101, 3'd2);
        for (int c = 1; c <= n; c++) begin
            if (c > 1) step();
            check_val($sformatf("%s c%0d beep", tag, c), 32'(bus.beep), 32'(eb[c]));
            check_val($sformatf("%s c%0d busy", tag, c), 32'(bus.busy), 32'(ebusy[c]));
            check_val($sformatf("%s c%0d done", tag, c), 32'(bus.done), 32'(edone[c]));
            if (chk_sym)
                check_val($sformatf("%s c%0d sym_idx", tag, c), 32'(bus.sym_idx),
                          32'(esym[4*c +: 4]));
            if (c == inj_c && inj == 1) begin
                bus.start = 1'b1;
                step();
                bus.start = 1'b0;
                c++;
                check_val($sformatf("%s c%0d beep", tag, c), 32'(bus.beep), 32'(eb[c]));
                check_val($sformatf("%s c%0d busy", tag, c), 32'(bus.busy), 32'(ebusy[c]));
                check_val($sformatf("%s c%0d done", tag, c), 32'(bus.done), 32'(edone[c]));
            end else if (c == inj_c && inj == 2) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                check_val({tag, " rst beep"}, 32'(bus.beep), 0);
                check_val({tag, " rst busy"}, 32'(bus.busy), 0);
                check_val({tag, " rst done"}, 32'(bus.done), 0);
                check_val({tag, " rst sym_idx"}, 32'(bus.sym_idx), 0);
                break;
            end
        end
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        setup(16'd0, 4'd1, 4'd3, 4'd1, 5'b00010, 3'd3);
        step();
        step();
        check_val("reset beep", 32'(bus.beep), 0);
        check_val("reset busy", 32'(bus.busy), 0);
        check_val("reset done", 32'(bus.done), 0);
        check_val("reset sym_idx", 32'(bus.sym_idx), 0);

        // Reset wins over a simultaneous start.
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check_val("rst prio busy", 32'(bus.busy), 0);
        rst = 1'b0;
        step();
        check_val("idle busy", 32'(bus.busy), 0);

        setup(16'd0, 4'd1, 4'd3, 4'd1, 5'b00010, 3'd3);
        run("basic", 10, BeepA, 32'h1FE, 32'h200, 1'b1, SymA, 0, 0, 1'b1);

        setup(16'd3, 4'd2, 4'd3, 4'd0, 5'b00000, 3'd1);
        run("prescale", 14, BeepB, 32'h1FFE, 32'h2000, 1'b0, '0, 0, 0, 1'b1);

        setup(16'd0, 4'd1, 4'd3, 4'd1, 5'b00010, 3'd0);
        run("len0", 3, 32'h0, 32'h0, 32'h2, 1'b0, '0, 0, 0, 1'b0);

        setup(16'd0, 4'd1, 4'd3, 4'd1, 5'b00010, 3'd3);
        run("busy_start", 10, BeepA, 32'h1FE, 32'h200, 1'b1, SymA, 1, 4, 1'b0);

        setup(16'd0, 4'd1, 4'd3, 4'd1, 5'b00010, 3'd3);
        run("abort", 4, BeepA, 32'h1FE, 32'h200, 1'b1, SymA, 2, 4, 1'b0);
        step();
        check_val("abort c6 done", 32'(bus.done), 0);
        setup(16'd0, 4'd1, 4'd3, 4'd1, 5'b00010, 3'd3);
        run("restart", 10, BeepA, 32'h1FE, 32'h200, 1'b1, SymA, 0, 0, 1'b0);

        setup(16'd0, 4'd1, 4'd1, 4'd1, 5'b00000, 3'd1);
        run("b2b", 7, 32'h12, 32'h36, 32'h48, 1'b0, '0, 1, 3, 1'b0);

        // Length 7 clamps to 5 symbols; zero-length fields act as one unit.
        setup(16'd0, 4'd0, 4'd0, 4'd0, 5'b10101, 3'd7);
        run("clamp", 12, 32'h2AA, 32'h7FE, 32'h800, 1'b0, '0, 0, 0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
